// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the game logic block.
// Synchronises the raw PS/2 lines, deframes 11-bit frames, and turns make/break
// scan codes into held-key levels for the left (W/S) and right (Up/Down arrow) pads.
// Optional build macro: PS2_PARITY_CHECK_EN enables the odd-parity check in the stop state.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES  = 50000,
  parameter logic [7:0]  LEFT_UP_CODE    = 8'h1D,
  parameter logic [7:0]  LEFT_DOWN_CODE  = 8'h1B,
  parameter logic [7:0]  RIGHT_UP_CODE   = 8'h75,
  parameter logic [7:0]  RIGHT_DOWN_CODE = 8'h72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] keys_left,
  output logic [1:0] keys_right,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchroniser and edge-detect flops (preset high: idle PS/2 bus level)
  logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic ps2_data_meta_q, ps2_data_sync_q;
  logic fall;

  // Frame receiver state
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            scan_valid_q, scan_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_good;
  logic            parity_ok;

  // Decoder state
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [1:0] keys_left_q, keys_left_d;
  logic [1:0] keys_right_q, keys_right_d;

  assign fall        = ps2_clk_prev_q & ~ps2_clk_sync_q;
  // Odd parity over data plus parity bit
  assign parity_good = ^{shreg_q, parity_q};

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = parity_good;
`else
  // Parity bit is latched but not enforced in this build
  logic unused_parity_good;
  assign unused_parity_good = parity_good;
  assign parity_ok = 1'b1;
`endif

  // Two-flop synchronisers plus a delayed copy of the clock for fall detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_clk_prev_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
    end else begin
      ps2_clk_meta_q  <= ps2_clk;
      ps2_clk_sync_q  <= ps2_clk_meta_q;
      ps2_clk_prev_q  <= ps2_clk_sync_q;
      ps2_data_meta_q <= ps2_data;
      ps2_data_sync_q <= ps2_data_meta_q;
    end
  end

  // Frame FSM and timeout counter: next-state and registered output pulses
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall || (state_q == StIdle)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if ((state_q != StIdle) && !fall && (cnt_q == CntLast)) begin
      // Stalled partial frame: abandon it
      state_d     = StIdle;
      bit_cnt_d   = '0;
      cnt_d       = '0;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!ps2_data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shreg_d = {ps2_data_sync_q, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StParity: begin
          parity_d = ps2_data_sync_q;
          state_d  = StStop;
        end
        StStop: begin
          if (ps2_data_sync_q && parity_ok) begin
            scan_code_d  = shreg_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d   = StIdle;
          bit_cnt_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      cnt_q        <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      cnt_q        <= cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Scan-code decoder: prefix flags and per-key held levels
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    keys_left_d  = keys_left_q;
    keys_right_d = keys_right_q;
    if (scan_valid_q) begin
      if (scan_code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q && (scan_code_q == LEFT_UP_CODE))    keys_left_d[1]  = ~brk_q;
        if (!ext_q && (scan_code_q == LEFT_DOWN_CODE))  keys_left_d[0]  = ~brk_q;
        if (ext_q  && (scan_code_q == RIGHT_UP_CODE))   keys_right_d[1] = ~brk_q;
        if (ext_q  && (scan_code_q == RIGHT_DOWN_CODE)) keys_right_d[0] = ~brk_q;
        // Any non-prefix byte terminates the prefix sequence
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Decoder state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keys_left_q  <= 2'b00;
      keys_right_q <= 2'b00;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keys_left_q  <= keys_left_d;
      keys_right_q <= keys_right_d;
    end
  end

  assign keys_left  = keys_left_q;
  assign keys_right = keys_right_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of frames with expected key levels
// and pulse counts, plus hand sequences for timeout and mid-frame reset.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] keys_left;
  logic [1:0] keys_right;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  logic [7:0] last_code = 8'h00;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keys_left  (keys_left),
    .keys_right (keys_right),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulse cycles away from the active edge
  always @(negedge clk) begin
    if (scan_valid) n_valid++;
    if (frame_err)  n_err++;
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_stop;
    bit         bad_par;
    logic [1:0] exp_l;
    logic [1:0] exp_r;
    int         dv;
    int         de;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the first nbits of a frame: start, D0..D7, parity, stop; 40 clk half-period
  task automatic send_bits(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                           input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(20);
      ps2_clk = 1'b0;
      wait_clk(40);
      ps2_clk = 1'b1;
      wait_clk(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_bits(v.code, v.bad_stop, v.bad_par, 11);
    wait_clk(20);
    if (v.dv > 0) last_code = v.code;
    check($sformatf("v%0d_valid_cnt", idx), n_valid - v0, v.dv);
    check($sformatf("v%0d_err_cnt", idx), n_err - e0, v.de);
    check($sformatf("v%0d_scan_code", idx), int'(scan_code), int'(last_code));
    check($sformatf("v%0d_keys_left", idx), int'(keys_left), int'(v.exp_l));
    check($sformatf("v%0d_keys_right", idx), int'(keys_right), int'(v.exp_r));
  endtask

  vec_t tab_a[11];
  vec_t tab_b[6];

  initial begin
    int v0, e0;
    //            code   stop  par   L      R      dv de
    tab_a[0]  = '{8'h1D, 1'b0, 1'b0, 2'b10, 2'b00, 1, 0};
    tab_a[1]  = '{8'hF0, 1'b0, 1'b0, 2'b10, 2'b00, 1, 0};
    tab_a[2]  = '{8'h1D, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0};
    tab_a[3]  = '{8'hE0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0};
    tab_a[4]  = '{8'h75, 1'b0, 1'b0, 2'b00, 2'b10, 1, 0};
    tab_a[5]  = '{8'hE0, 1'b0, 1'b0, 2'b00, 2'b10, 1, 0};
    tab_a[6]  = '{8'h72, 1'b0, 1'b0, 2'b00, 2'b11, 1, 0};
    tab_a[7]  = '{8'hE0, 1'b0, 1'b0, 2'b00, 2'b11, 1, 0};
    tab_a[8]  = '{8'hF0, 1'b0, 1'b0, 2'b00, 2'b11, 1, 0};
    tab_a[9]  = '{8'h75, 1'b0, 1'b0, 2'b00, 2'b01, 1, 0};
    tab_a[10] = '{8'h75, 1'b0, 1'b0, 2'b00, 2'b01, 1, 0};

    tab_b[0]  = '{8'h1B, 1'b0, 1'b0, 2'b01, 2'b01, 1, 0};
    tab_b[1]  = '{8'hF0, 1'b0, 1'b0, 2'b01, 2'b01, 1, 0};
    tab_b[2]  = '{8'h1B, 1'b0, 1'b0, 2'b00, 2'b01, 1, 0};
    tab_b[3]  = '{8'h1D, 1'b1, 1'b0, 2'b00, 2'b01, 0, 1};
`ifdef PS2_PARITY_CHECK_EN
    tab_b[4]  = '{8'h1D, 1'b0, 1'b1, 2'b00, 2'b01, 0, 1};
`else
    tab_b[4]  = '{8'h1D, 1'b0, 1'b1, 2'b10, 2'b01, 1, 0};
`endif
    tab_b[5]  = '{8'hE0, 1'b0, 1'b0, 2'b00, 2'b01, 1, 0};
`ifndef PS2_PARITY_CHECK_EN
    tab_b[5].exp_l = 2'b10;
`endif

    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    check("reset_keys_left", int'(keys_left), 0);
    check("reset_keys_right", int'(keys_right), 0);
    check("reset_scan_code", int'(scan_code), 0);
    check("reset_scan_valid", int'(scan_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 11; i++) run_vec(tab_a[i], i);

    // Partial frame then idle: one timeout error, no byte
    v0 = n_valid;
    e0 = n_err;
    send_bits(8'h1B, 1'b0, 1'b0, 5);
    wait_clk(250);
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_valid_cnt", n_valid - v0, 0);

    for (int i = 0; i < 6; i++) run_vec(tab_b[i], 100 + i);

    // Right pad to 2'b11 (ext already pending from the last row), then reset mid-frame
    send_bits(8'h75, 1'b0, 1'b0, 11);
    wait_clk(20);
    check("pre_reset_keys_right", int'(keys_right), 3);
    v0 = n_valid;
    e0 = n_err;
    send_bits(8'h72, 1'b0, 1'b0, 3);
    rst = 1'b0;
    #1;
    check("async_rst_keys_right", int'(keys_right), 0);
    check("async_rst_keys_left", int'(keys_left), 0);
    check("async_rst_scan_code", int'(scan_code), 0);
    wait_clk(5);
    rst = 1'b1;
    wait_clk(10);
    check("rst_abort_valid_cnt", n_valid - v0, 0);
    check("rst_abort_err_cnt", n_err - e0, 0);

    last_code = 8'h00;
    run_vec('{8'h1B, 1'b0, 1'b0, 2'b01, 2'b00, 1, 0}, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
